// File: rtl/inst_fetch_axi.sv
// Instruction-fetch front end: turns an F-stage fetch request into one single-beat AXI4 read.
// Optional last-hit buffer enabled by defining IF_LASTHIT_EN.
module inst_fetch_axi (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] pc_f,
  input  logic        fetch_req,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr_f,
  output logic        instr_valid,
  output logic        fetch_stall,
  output logic        adel_f,
  output logic        ibus_err_f,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AR      = 3'd1,
    S_R       = 3'd2,
    S_DONE    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        pend_flush_r;
  logic        accept_s;
  logic        misalign_s;
  logic        beat_s;
  logic        ar_hs_s;
  logic        lh_hit_s;
  logic [31:0] lh_data_s;
  logic        unused_ok_s;

  assign arid        = 4'd0;
  assign arlen       = 8'd0;
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
  assign unused_ok_s = ^rid;

  assign accept_s    = (state_r == S_IDLE) && fetch_req && !flush;
  assign misalign_s  = (pc_f[1:0] != 2'b00);
  assign beat_s      = rvalid && rlast;
  assign ar_hs_s     = arvalid && arready;
  assign fetch_stall = fetch_req && (state_r != S_DONE);

`ifdef IF_LASTHIT_EN
  logic        lh_valid_r;
  logic [31:0] lh_addr_r;
  logic [31:0] lh_data_r;

  assign lh_hit_s  = lh_valid_r && (pc_f == lh_addr_r);
  assign lh_data_s = lh_data_r;

  // Last-hit buffer: filled by OKAY beats only, dropped on any flush
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lh_valid_r <= 1'b0;
      lh_addr_r  <= 32'd0;
      lh_data_r  <= 32'd0;
    end else if (flush) begin
      lh_valid_r <= 1'b0;
    end else if ((state_r == S_R) && beat_s && (rresp == 2'b00)) begin
      lh_valid_r <= 1'b1;
      lh_addr_r  <= araddr;
      lh_data_r  <= rdata;
    end
  end
`else
  assign lh_hit_s  = 1'b0;
  assign lh_data_s = 32'd0;
`endif

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (misalign_s || lh_hit_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_AR;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_AR: begin
        if (ar_hs_s) begin
          if (flush || pend_flush_r) begin
            state_nxt_s = S_DISCARD;
          end else begin
            state_nxt_s = S_R;
          end
        end else begin
          state_nxt_s = S_AR;
        end
      end
      S_R: begin
        // a flush coinciding with the beat drops the data and skips DISCARD
        if (beat_s && flush) begin
          state_nxt_s = S_IDLE;
        end else if (beat_s) begin
          state_nxt_s = S_DONE;
        end else if (flush) begin
          state_nxt_s = S_DISCARD;
        end else begin
          state_nxt_s = S_R;
        end
      end
      S_DONE: begin
        if (flush || !stall) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_DISCARD: begin
        if (beat_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DISCARD;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and handshake outputs registered from the next state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= S_IDLE;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      arvalid     <= (state_nxt_s == S_AR);
      rready      <= (state_nxt_s == S_R) || (state_nxt_s == S_DISCARD);
      instr_valid <= (state_nxt_s == S_DONE);
    end
  end

  // Fetch address and pending-flush tracking during the address phase
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      araddr       <= 32'd0;
      pend_flush_r <= 1'b0;
    end else begin
      if (accept_s) begin
        araddr <= pc_f;
      end
      if ((state_r == S_AR) && !ar_hs_s) begin
        pend_flush_r <= pend_flush_r || flush;
      end else begin
        pend_flush_r <= 1'b0;
      end
    end
  end

  // Result capture; instr_f is left alone on exit since instr_valid qualifies it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      instr_f    <= 32'd0;
      adel_f     <= 1'b0;
      ibus_err_f <= 1'b0;
    end else if (accept_s && misalign_s) begin
      instr_f    <= 32'd0;
      adel_f     <= 1'b1;
      ibus_err_f <= 1'b0;
    end else if (accept_s && lh_hit_s) begin
      instr_f    <= lh_data_s;
      adel_f     <= 1'b0;
      ibus_err_f <= 1'b0;
    end else if ((state_r == S_R) && beat_s && !flush) begin
      instr_f    <= (rresp != 2'b00) ? 32'd0 : rdata;
      adel_f     <= 1'b0;
      ibus_err_f <= (rresp != 2'b00);
    end else if ((state_r == S_DONE) && (state_nxt_s != S_DONE)) begin
      adel_f     <= 1'b0;
      ibus_err_f <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Directed bench for inst_fetch_axi with a result scoreboard; the AXI slave is driven inline.
module tb_inst_fetch_axi;

  logic        aclk;
  logic        aresetn;
  logic [31:0] pc_f;
  logic        fetch_req, stall, flush;
  logic [31:0] instr_f;
  logic        instr_valid, fetch_stall, adel_f, ibus_err_f;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  typedef struct packed {
    logic [31:0] instr;
    logic        adel;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  inst_fetch_axi dut (
    .aclk(aclk), .aresetn(aresetn), .pc_f(pc_f), .fetch_req(fetch_req),
    .stall(stall), .flush(flush), .instr_f(instr_f), .instr_valid(instr_valid),
    .fetch_stall(fetch_stall), .adel_f(adel_f), .ibus_err_f(ibus_err_f),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
    end else begin
      e = '0;
    end
    chk({tag, "_instr"}, instr_f, e.instr);
    chk({tag, "_adel"}, {31'd0, adel_f}, {31'd0, e.adel});
    chk({tag, "_err"}, {31'd0, ibus_err_f}, {31'd0, e.err});
  endtask

  // Request accepted at the next edge; returns in cycle 3 with the beat consumed.
  task automatic issue_read(input logic [31:0] pc, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    e.instr = (resp == 2'b00) ? data : 32'd0;
    e.adel  = 1'b0;
    e.err   = (resp != 2'b00);
    sb_q.push_back(e);
    fetch_req = 1'b1; pc_f = pc; arready = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("rd_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rd_araddr", araddr, pc);
    chk("rd_nv_c1", {31'd0, instr_valid}, 32'd0);
    step();
    chk("rd_rready", {31'd0, rready}, 32'd1);
    chk("rd_arvalid_low", {31'd0, arvalid}, 32'd0);
    chk("rd_nv_c2", {31'd0, instr_valid}, 32'd0);
    rvalid = 1'b1; rlast = 1'b1; rdata = data; rresp = resp; arready = 1'b0;
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rresp = 2'b00;
  endtask

  initial begin
    aresetn = 1'b0; pc_f = 32'd0; fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    step(); step();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_instr", instr_f, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_adel", {31'd0, adel_f}, 32'd0);
    chk("rst_err", {31'd0, ibus_err_f}, 32'd0);
    fetch_req = 1'b1; #1;
    chk("rst_fstall_hi", {31'd0, fetch_stall}, 32'd1);
    fetch_req = 1'b0; #1;
    chk("rst_fstall_lo", {31'd0, fetch_stall}, 32'd0);
    chk("const_ar", {arid, arlen, arsize, arburst}, {15'd0, 4'd0, 8'd0, 3'b010, 2'b01});
    aresetn = 1'b1;
    step();

    // basic fetch
    issue_read(32'hBFC0_0000, 32'h2408_0001, 2'b00);
    pop_check("basic");
    fetch_req = 1'b1; pc_f = 32'hBFC0_0000; #1;
    chk("basic_fstall_done", {31'd0, fetch_stall}, 32'd0);
    fetch_req = 1'b0;
    step();
    chk("basic_exit", {31'd0, instr_valid}, 32'd0);

    // stall hold for 4 cycles
    issue_read(32'h0000_0100, 32'hA5A5_0001, 2'b00);
    pop_check("stall");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr_f, 32'hA5A5_0001);
      step();
    end
    chk("stall_still_done", {31'd0, instr_valid}, 32'd1);
    stall = 1'b0;
    step();
    chk("stall_release", {31'd0, instr_valid}, 32'd0);

    // flush in R, one cycle before the beat
    fetch_req = 1'b1; pc_f = 32'h0000_0200; arready = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    arready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flr_rready", {31'd0, rready}, 32'd1);
    chk("flr_nv", {31'd0, instr_valid}, 32'd0);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
    chk("flr_idle_rready", {31'd0, rready}, 32'd0);
    chk("flr_nv2", {31'd0, instr_valid}, 32'd0);
    step();
    chk("flr_nv3", {31'd0, instr_valid}, 32'd0);
    chk("flr_no_arvalid", {31'd0, arvalid}, 32'd0);

    // misaligned
    sb_q.push_back('{instr: 32'd0, adel: 1'b1, err: 1'b0});
    fetch_req = 1'b1; pc_f = 32'h0000_0002; arready = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("mis_arvalid", {31'd0, arvalid}, 32'd0);
    pop_check("mis");
    step();
    chk("mis_exit_valid", {31'd0, instr_valid}, 32'd0);
    chk("mis_exit_adel", {31'd0, adel_f}, 32'd0);
    chk("mis_arvalid2", {31'd0, arvalid}, 32'd0);
    arready = 1'b0;

    // bus error
    issue_read(32'h0000_0300, 32'h1234_5678, 2'b10);
    pop_check("buserr");
    step();
    chk("buserr_clear", {31'd0, ibus_err_f}, 32'd0);

    // flush during address phase before arready: pending flush forces DISCARD
    fetch_req = 1'b1; pc_f = 32'h0000_0400; arready = 1'b0;
    step();
    fetch_req = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; arready = 1'b1;
    chk("far_arvalid_held", {31'd0, arvalid}, 32'd1);
    step();
    arready = 1'b0;
    chk("far_discard_rready", {31'd0, rready}, 32'd1);
    chk("far_arvalid_low", {31'd0, arvalid}, 32'd0);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFE_0001;
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
    chk("far_nv", {31'd0, instr_valid}, 32'd0);
    chk("far_idle", {31'd0, rready}, 32'd0);

    // flush in the same cycle as the beat goes straight to IDLE
    fetch_req = 1'b1; pc_f = 32'h0000_0500; arready = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    arready = 1'b0; flush = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5555_AAAA;
    step();
    flush = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
    chk("fbeat_nv", {31'd0, instr_valid}, 32'd0);
    chk("fbeat_rready", {31'd0, rready}, 32'd0);

    // repeated fetch of the same PC
    issue_read(32'h8000_0000, 32'h1111_2222, 2'b00);
    pop_check("lh_first");
    step();
`ifdef IF_LASTHIT_EN
    sb_q.push_back('{instr: 32'h1111_2222, adel: 1'b0, err: 1'b0});
    fetch_req = 1'b1; pc_f = 32'h8000_0000; arready = 1'b1;
    step();
    fetch_req = 1'b0; arready = 1'b0;
    chk("lh_hit_noar", {31'd0, arvalid}, 32'd0);
    pop_check("lh_hit");
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("lh_flush_exit", {31'd0, instr_valid}, 32'd0);
`endif
    issue_read(32'h8000_0000, 32'h1111_2222, 2'b00);
    pop_check("lh_again");
    step();

    // reset in the middle of the address phase
    fetch_req = 1'b1; pc_f = 32'h0000_0600; arready = 1'b0;
    step();
    fetch_req = 1'b0;
    chk("mid_arvalid", {31'd0, arvalid}, 32'd1);
    aresetn = 1'b0; #1;
    chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_rst_araddr", araddr, 32'd0);
    step();
    aresetn = 1'b1;
    step();
    chk("mid_post_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_post_valid", {31'd0, instr_valid}, 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
